nl2_dbank_scrub_gen: RTL and testbench
======================================

# nl2_dbank_scrub_gen

Background scrub sequencer for the L2 data banks. It walks every block address of every enabled SRAM bank and issues one scrub command at a time on the scrub request interface (`req_scrub`/`req_ack`/`req_bnk`/`req_addr`). It then waits for the bank-side scrub controller to report completion before pacing the next command. It sits next to the dbank scrub control logic on the initiator side of that handshake and is programmed from the cluster control registers.

## Interface
Parameters:
- `N_SRAM`, 4: number of data banks; legal values are 2 and 4.
- `BLOCK_ADDR_SIZE`, `` `nl2_SRAM_BLOCK_ADDR_SIZE ``: width of a bank block address.
- `INTERVAL_W`, 16: width of the pacing interval.

Ports:
- `clk`  in  1: clock.
- `rst_a`  in  1: reset. Synchronous, active-high.
- `scrub_enable`  in  1: sequencer run enable.
- `scrub_interval`  in  `INTERVAL_W`: idle cycles between commands.
- `scrub_bnk_mask`  in  `N_SRAM`: banks included in the sweep.
- `req_scrub`  out  1: scrub command valid.
- `req_ack`  in  1: command captured by the bank side.
- `req_bnk`  out  `N_SRAM`: one-hot target bank.
- `req_addr`  out  `BLOCK_ADDR_SIZE`: target block address.
- `scrub_proc`  in  1: one-cycle completion pulse from the bank side.
- `busy`  out  1: state is not IDLE.
- `sweep_done`  out  1: one-cycle pulse when a full sweep wraps.
- `sweep_count`  out  16: completed sweeps, saturating at 16'hFFFF.

## Operation
- Position state:
  - `bnk_idx` (log2 `N_SRAM` bits) and `addr` (`BLOCK_ADDR_SIZE` bits).
  - `req_bnk` = one-hot of `bnk_idx`; `req_addr` = `addr`.
- FSM states: IDLE, WAIT, REQ, CMPL.
- IDLE:
  - Stays while `scrub_enable`=0 or `scrub_bnk_mask`=0.
  - Otherwise moves to WAIT and loads `cnt`=`scrub_interval`.
  - If `scrub_bnk_mask[bnk_idx]`=0, `bnk_idx` moves to the lowest set mask bit; `addr` is unchanged.
- WAIT:
  - `scrub_enable`=0 → IDLE, position retained.
  - `cnt`=0 → REQ; otherwise `cnt` decrements.
- REQ:
  - `req_scrub`=1.
  - `req_bnk`/`req_addr` are held stable until `req_ack`.
  - The request is never withdrawn, even if `scrub_enable` drops.
  - `req_ack` → CMPL.
- CMPL:
  - Waits for `scrub_proc`.
  - On `scrub_proc`, the position advances. Then the FSM goes to WAIT (reload `cnt`) if enabled with a nonzero mask, else IDLE.
- Advance rule:
  - `bnk_idx` moves to the next set bit of `scrub_bnk_mask` above the current index.
  - If there is none, `bnk_idx` moves to the lowest set bit and `addr` increments.
  - When `addr` wraps from all-ones to 0, `sweep_done` pulses and `sweep_count` increments (saturating).
- Mask is sampled only at IDLE→WAIT and at advance. A mask change never alters an in-flight request.
- `req_ack` or `scrub_proc` outside REQ/CMPL is ignored and has no state effect.
- Single-bank mask: `bnk_idx` is constant and `addr` increments every command.

## Timing
- Reset values:
  - state=IDLE; `bnk_idx`=0, `addr`=0, `cnt`=0.
  - `req_scrub`=0, `req_bnk`=0001 (one-hot of index 0), `req_addr`=0.
  - `busy`=0, `sweep_done`=0, `sweep_count`=0.
- Reset mid-operation returns to these values on the next edge; any in-flight request is dropped.
- Command pacing:
  - Enable rises at cycle 0 → WAIT at cycle 1.
  - With `scrub_interval`=N, WAIT lasts N+1 cycles, so `req_scrub` first rises at cycle N+2.
- `req_ack` in the first REQ cycle → CMPL next cycle; `req_scrub` is low for that cycle.
- `scrub_proc` in CMPL → the advanced position is visible on `req_bnk`/`req_addr` the next cycle, together with WAIT.
- `sweep_done` is registered and is high in the cycle after the wrapping `scrub_proc`.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.

## Structure
- Shared package `nl2_scrub_pkg`:
  - FSM state enum `scrub_gen_state_t` (IDLE/WAIT/REQ/CMPL).
  - `SCRUB_SWEEP_CNT_W` = 16.
- One natural sub-module: `nl2_scrub_next_bnk`. It is a combinational next-set-bit-above-index finder with wrap flag and lowest-set-bit output, parameterised by `N_SRAM`.

## Test plan
- Reset, then enable with `scrub_interval`=3 and mask 4'b1111:
  - First `req_scrub` at cycle 5 with `req_bnk`=0001, `req_addr`=0.
  - Ack plus proc one cycle later → next request `req_bnk`=0010, `addr`=0.
- Mask 4'b1010, `BLOCK_ADDR_SIZE` forced to 2, `scrub_interval`=0, ack and proc immediate:
  - Sequence is (b1,0),(b3,0),(b1,1),…,(b3,3).
  - `sweep_done` pulses once, then the sequence restarts at (b1,0) and `sweep_count`=1.
- Hold `req_ack` low for 10 cycles in REQ and drop `scrub_enable` mid-way:
  - `req_scrub` stays high with stable bank/address.
  - After ack and proc → IDLE, `busy`=0.
  - Re-enable resumes at the advanced position.
- Disable during WAIT → IDLE within 1 cycle with no request.
- Mask changed from 4'b1111 to 4'b0100 while in CMPL at bank 0 → next request targets bank 2, same address.
- Stray `req_ack`/`scrub_proc` pulses in IDLE/WAIT → no state change.
- Assert `rst_a` during CMPL → all outputs return to their reset values the next cycle.
- Force `sweep_count` to FFFF and complete a sweep → `sweep_count` stays FFFF and `sweep_done` still pulses.

Source files
------------

// File: rtl/nl2_scrub_pkg.sv
// Shared types and helpers for the L2 data-bank background scrub sequencer.
// Provides the FSM state encoding and the saturating sweep counter increment.
`ifndef nl2_SRAM_BLOCK_ADDR_SIZE
`define nl2_SRAM_BLOCK_ADDR_SIZE 10
`endif

package nl2_scrub_pkg;

    localparam int SCRUB_SWEEP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_CMPL = 2'd3
    } scrub_gen_state_t;

    function automatic logic [SCRUB_SWEEP_CNT_W-1:0] sweep_cnt_sat_inc(
        input logic [SCRUB_SWEEP_CNT_W-1:0] cnt
    );
        return (&cnt) ? cnt : cnt + SCRUB_SWEEP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/nl2_scrub_next_bnk.sv
// Finds the next set mask bit strictly above the current bank index, plus the
// lowest set bit used when the search wraps around.
module nl2_scrub_next_bnk #(
    parameter int N_SRAM = 4,
    parameter int IDX_W  = (N_SRAM > 1) ? $clog2(N_SRAM) : 1
) (
    input  logic [N_SRAM-1:0] mask,
    input  logic [IDX_W-1:0]  cur_idx,
    output logic [IDX_W-1:0]  next_idx,
    output logic              wrap,
    output logic [IDX_W-1:0]  low_idx,
    output logic              any_set
);

    // Scanning downward leaves the lowest qualifying bit as the final winner.
    always_comb begin
        next_idx = '0;
        wrap     = 1'b1;
        low_idx  = '0;
        for (int i = N_SRAM - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IDX_W'(i);
                if (i > int'(cur_idx)) begin
                    next_idx = IDX_W'(i);
                    wrap     = 1'b0;
                end
            end
        end
    end

    assign any_set = |mask;

endmodule

// File: rtl/nl2_dbank_scrub_gen.sv
// Background scrub sequencer: walks every block address of every enabled bank,
// issuing one paced scrub command at a time and waiting for bank-side completion.
module nl2_dbank_scrub_gen
    import nl2_scrub_pkg::*;
#(
    parameter int N_SRAM          = 4,
    parameter int BLOCK_ADDR_SIZE = `nl2_SRAM_BLOCK_ADDR_SIZE,
    parameter int INTERVAL_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_a,
    input  logic                         scrub_enable,
    input  logic [INTERVAL_W-1:0]        scrub_interval,
    input  logic [N_SRAM-1:0]            scrub_bnk_mask,
    output logic                         req_scrub,
    input  logic                         req_ack,
    output logic [N_SRAM-1:0]            req_bnk,
    output logic [BLOCK_ADDR_SIZE-1:0]   req_addr,
    input  logic                         scrub_proc,
    output logic                         busy,
    output logic                         sweep_done,
    output logic [SCRUB_SWEEP_CNT_W-1:0] sweep_count
);

    localparam int IDX_W = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;

    scrub_gen_state_t               state_q, state_d;
    logic [IDX_W-1:0]               bnk_idx_q, bnk_idx_d;
    logic [BLOCK_ADDR_SIZE-1:0]     addr_q, addr_d;
    logic [INTERVAL_W-1:0]          cnt_q, cnt_d;
    logic                           req_scrub_q, req_scrub_d;
    logic                           busy_q, busy_d;
    logic                           sweep_done_q, sweep_done_d;
    logic [SCRUB_SWEEP_CNT_W-1:0]   sweep_count_q, sweep_count_d;

    logic [IDX_W-1:0]               nb_next_idx;
    logic                           nb_wrap;
    logic [IDX_W-1:0]               nb_low_idx;
    logic                           nb_any_set;

    nl2_scrub_next_bnk #(
        .N_SRAM (N_SRAM),
        .IDX_W  (IDX_W)
    ) u_next_bnk (
        .mask     (scrub_bnk_mask),
        .cur_idx  (bnk_idx_q),
        .next_idx (nb_next_idx),
        .wrap     (nb_wrap),
        .low_idx  (nb_low_idx),
        .any_set  (nb_any_set)
    );

    always_comb begin
        state_d       = state_q;
        bnk_idx_d     = bnk_idx_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        sweep_done_d  = 1'b0;
        sweep_count_d = sweep_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (scrub_enable && nb_any_set) begin
                    state_d = ST_WAIT;
                    cnt_d   = scrub_interval;
                    if (!scrub_bnk_mask[bnk_idx_q]) begin
                        bnk_idx_d = nb_low_idx;
                    end
                end
            end
            ST_WAIT: begin
                if (!scrub_enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q - INTERVAL_W'(1);
                end
            end
            ST_REQ: begin
                // The command stays up until acknowledged, regardless of enable.
                if (req_ack) begin
                    state_d = ST_CMPL;
                end
            end
            ST_CMPL: begin
                if (scrub_proc) begin
                    if (!nb_wrap) begin
                        bnk_idx_d = nb_next_idx;
                    end else begin
                        bnk_idx_d = nb_low_idx;
                        addr_d    = addr_q + BLOCK_ADDR_SIZE'(1);
                        if (&addr_q) begin
                            sweep_done_d  = 1'b1;
                            sweep_count_d = sweep_cnt_sat_inc(sweep_count_q);
                        end
                    end
                    if (scrub_enable && nb_any_set) begin
                        state_d = ST_WAIT;
                        cnt_d   = scrub_interval;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_scrub_d = (state_d == ST_REQ);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q       <= ST_IDLE;
            bnk_idx_q     <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            req_scrub_q   <= 1'b0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            sweep_count_q <= '0;
        end else begin
            state_q       <= state_d;
            bnk_idx_q     <= bnk_idx_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            req_scrub_q   <= req_scrub_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
            sweep_count_q <= sweep_count_d;
        end
    end

    always_comb begin
        req_bnk            = '0;
        req_bnk[bnk_idx_q] = 1'b1;
    end

    assign req_scrub   = req_scrub_q;
    assign req_addr    = addr_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_nl2_dbank_scrub_gen.sv
// Directed bench for nl2_dbank_scrub_gen with a 4-bank, 2-bit block address
// configuration so that full sweeps complete in a handful of commands.
module tb_nl2_dbank_scrub_gen;

    logic        clk;
    logic        rst_a;
    logic        scrub_enable;
    logic [15:0] scrub_interval;
    logic [3:0]  scrub_bnk_mask;
    logic        req_scrub;
    logic        req_ack;
    logic [3:0]  req_bnk;
    logic [1:0]  req_addr;
    logic        scrub_proc;
    logic        busy;
    logic        sweep_done;
    logic [15:0] sweep_count;

    int n_checks = 0;
    int n_fail   = 0;

    nl2_dbank_scrub_gen #(
        .N_SRAM          (4),
        .BLOCK_ADDR_SIZE (2),
        .INTERVAL_W      (16)
    ) dut (
        .clk            (clk),
        .rst_a          (rst_a),
        .scrub_enable   (scrub_enable),
        .scrub_interval (scrub_interval),
        .scrub_bnk_mask (scrub_bnk_mask),
        .req_scrub      (req_scrub),
        .req_ack        (req_ack),
        .req_bnk        (req_bnk),
        .req_addr       (req_addr),
        .scrub_proc     (scrub_proc),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .sweep_count    (sweep_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_a          = 1'b1;
        scrub_enable   = 1'b0;
        scrub_interval = '0;
        scrub_bnk_mask = '0;
        req_ack        = 1'b0;
        scrub_proc     = 1'b0;
        tick();
        tick();
        rst_a = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_scrub === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Ack in the REQ cycle, completion pulse in the CMPL cycle.
    task automatic serve();
        req_ack = 1'b1;
        tick();
        req_ack    = 1'b0;
        scrub_proc = 1'b1;
        tick();
        scrub_proc = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (req_scrub !== 1'b0) begin n_fail++; $display("FAIL reset_req_scrub: got %b expected 0", req_scrub); end
        n_checks++; if (req_bnk !== 4'b0001) begin n_fail++; $display("FAIL reset_req_bnk: got %b expected 0001", req_bnk); end
        n_checks++; if (req_addr !== 2'd0) begin n_fail++; $display("FAIL reset_req_addr: got %0d expected 0", req_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_done: got %b expected 0", sweep_done); end
        n_checks++; if (sweep_count !== 16'h0) begin n_fail++; $display("FAIL reset_sweep_count: got %h expected 0000", sweep_count); end
    endtask

    task automatic test_pacing();
        do_reset();
        scrub_interval = 16'd3;
        scrub_bnk_mask = 4'b1111;
        scrub_enable   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++; if (req_scrub !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pacing_wait_c%0d: got req=%b busy=%b expected req=0 busy=1", c, req_scrub, busy); end
        end
        tick();
        n_checks++; if (req_scrub !== 1'b1) begin n_fail++; $display("FAIL pacing_first_req_c5: got %b expected 1", req_scrub); end
        n_checks++; if (req_bnk !== 4'b0001 || req_addr !== 2'd0) begin n_fail++; $display("FAIL pacing_first_pos: got bnk=%b addr=%0d expected 0001/0", req_bnk, req_addr); end
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        n_checks++; if (req_scrub !== 1'b0) begin n_fail++; $display("FAIL pacing_cmpl_req_low: got %b expected 0", req_scrub); end
        scrub_proc = 1'b1;
        tick();
        scrub_proc = 1'b0;
        n_checks++; if (req_bnk !== 4'b0010 || req_addr !== 2'd0) begin n_fail++; $display("FAIL pacing_advanced_pos: got bnk=%b addr=%0d expected 0010/0", req_bnk, req_addr); end
        for (int c = 8; c <= 10; c++) begin
            tick();
            n_checks++; if (req_scrub !== 1'b0) begin n_fail++; $display("FAIL pacing_rewait_c%0d: got %b expected 0", c, req_scrub); end
        end
        tick();
        n_checks++; if (req_scrub !== 1'b1 || req_bnk !== 4'b0010) begin n_fail++; $display("FAIL pacing_second_req_c11: got req=%b bnk=%b expected 1/0010", req_scrub, req_bnk); end
    endtask

    task automatic test_sweep_wrap();
        bit ok;
        logic [3:0] exp_bnk;
        do_reset();
        scrub_interval = 16'd0;
        scrub_bnk_mask = 4'b1010;
        scrub_enable   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_req(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL sweep_req_timeout_k%0d: got no request expected request", k); end
            exp_bnk = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            n_checks++; if (req_bnk !== exp_bnk || req_addr !== 2'(k / 2)) begin n_fail++; $display("FAIL sweep_pos_k%0d: got bnk=%b addr=%0d expected %b/%0d", k, req_bnk, req_addr, exp_bnk, k / 2); end
            serve();
            n_checks++; if (sweep_done !== (k == 7)) begin n_fail++; $display("FAIL sweep_done_k%0d: got %b expected %b", k, sweep_done, (k == 7)); end
        end
        n_checks++; if (sweep_count !== 16'd1) begin n_fail++; $display("FAIL sweep_count_one: got %0d expected 1", sweep_count); end
        tick();
        n_checks++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL sweep_done_single_pulse: got %b expected 0", sweep_done); end
        wait_req(ok);
        n_checks++; if (!ok || req_bnk !== 4'b0010 || req_addr !== 2'd0) begin n_fail++; $display("FAIL sweep_restart: got ok=%b bnk=%b addr=%0d expected 1/0010/0", ok, req_bnk, req_addr); end
    endtask

    task automatic test_hold_ack();
        bit ok;
        bit stable;
        do_reset();
        scrub_interval = 16'd2;
        scrub_bnk_mask = 4'b1111;
        scrub_enable   = 1'b1;
        wait_req(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_req_timeout: got no request expected request"); end
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) scrub_enable = 1'b0;
            tick();
            if (req_scrub !== 1'b1 || req_bnk !== 4'b0001 || req_addr !== 2'd0) stable = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_req_stable: got req=%b bnk=%b addr=%0d expected 1/0001/0", req_scrub, req_bnk, req_addr); end
        serve();
        n_checks++; if (busy !== 1'b0 || req_scrub !== 1'b0) begin n_fail++; $display("FAIL hold_idle_after: got busy=%b req=%b expected 0/0", busy, req_scrub); end
        n_checks++; if (req_bnk !== 4'b0010) begin n_fail++; $display("FAIL hold_advanced_bnk: got %b expected 0010", req_bnk); end
        scrub_enable = 1'b1;
        tick();
        wait_req(ok);
        n_checks++; if (!ok || req_bnk !== 4'b0010 || req_addr !== 2'd0) begin n_fail++; $display("FAIL hold_resume: got ok=%b bnk=%b addr=%0d expected 1/0010/0", ok, req_bnk, req_addr); end
    endtask

    task automatic test_disable_wait();
        bit any_req;
        do_reset();
        scrub_interval = 16'd5;
        scrub_bnk_mask = 4'b1111;
        scrub_enable   = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dis_wait_busy: got %b expected 1", busy); end
        scrub_enable = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_wait_idle: got %b expected 0", busy); end
        any_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (req_scrub !== 1'b0) any_req = 1'b1;
        end
        n_checks++; if (any_req !== 1'b0) begin n_fail++; $display("FAIL dis_wait_no_req: got %b expected 0", any_req); end
    endtask

    task automatic test_mask_change();
        bit ok;
        do_reset();
        scrub_interval = 16'd0;
        scrub_bnk_mask = 4'b1111;
        scrub_enable   = 1'b1;
        wait_req(ok);
        n_checks++; if (!ok || req_bnk !== 4'b0001) begin n_fail++; $display("FAIL mask_first: got ok=%b bnk=%b expected 1/0001", ok, req_bnk); end
        req_ack = 1'b1;
        tick();
        req_ack        = 1'b0;
        scrub_bnk_mask = 4'b0100;
        scrub_proc     = 1'b1;
        tick();
        scrub_proc = 1'b0;
        n_checks++; if (req_bnk !== 4'b0100 || req_addr !== 2'd0) begin n_fail++; $display("FAIL mask_change_pos: got bnk=%b addr=%0d expected 0100/0", req_bnk, req_addr); end
        wait_req(ok);
        serve();
        wait_req(ok);
        n_checks++; if (!ok || req_bnk !== 4'b0100 || req_addr !== 2'd1) begin n_fail++; $display("FAIL single_bank_next: got ok=%b bnk=%b addr=%0d expected 1/0100/1", ok, req_bnk, req_addr); end
    endtask

    task automatic test_stray();
        bit bad;
        do_reset();
        scrub_interval = 16'd4;
        scrub_bnk_mask = 4'b1111;
        req_ack        = 1'b1;
        scrub_proc     = 1'b1;
        tick();
        req_ack    = 1'b0;
        scrub_proc = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || req_scrub !== 1'b0 || req_bnk !== 4'b0001 || req_addr !== 2'd0) begin n_fail++; $display("FAIL stray_idle: got busy=%b req=%b bnk=%b addr=%0d expected 0/0/0001/0", busy, req_scrub, req_bnk, req_addr); end
        scrub_enable = 1'b1;
        bad = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (req_scrub !== 1'b0) bad = 1'b1;
            req_ack    = (c == 2 || c == 3);
            scrub_proc = (c == 2 || c == 3);
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL stray_wait_no_req: got %b expected 0", bad); end
        tick();
        n_checks++; if (req_scrub !== 1'b1 || req_bnk !== 4'b0001 || req_addr !== 2'd0) begin n_fail++; $display("FAIL stray_req_c6: got req=%b bnk=%b addr=%0d expected 1/0001/0", req_scrub, req_bnk, req_addr); end
    endtask

    task automatic test_reset_cmpl();
        bit ok;
        do_reset();
        scrub_interval = 16'd0;
        scrub_bnk_mask = 4'b1111;
        scrub_enable   = 1'b1;
        wait_req(ok);
        serve();
        wait_req(ok);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        n_checks++; if (busy !== 1'b1 || req_bnk !== 4'b0010) begin n_fail++; $display("FAIL rstc_pre: got busy=%b bnk=%b expected 1/0010", busy, req_bnk); end
        rst_a = 1'b1;
        tick();
        rst_a        = 1'b0;
        scrub_enable = 1'b0;
        n_checks++; if (req_scrub !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0) begin n_fail++; $display("FAIL rstc_ctrl: got req=%b busy=%b done=%b expected 0/0/0", req_scrub, busy, sweep_done); end
        n_checks++; if (req_bnk !== 4'b0001 || req_addr !== 2'd0 || sweep_count !== 16'd0) begin n_fail++; $display("FAIL rstc_pos: got bnk=%b addr=%0d cnt=%0d expected 0001/0/0", req_bnk, req_addr, sweep_count); end
    endtask

    task automatic test_saturate();
        bit ok;
        do_reset();
        scrub_interval = 16'd0;
        scrub_bnk_mask = 4'b0001;
        scrub_enable   = 1'b1;
        force dut.sweep_count_q = 16'hFFFF;
        tick();
        release dut.sweep_count_q;
        for (int k = 0; k < 4; k++) begin
            wait_req(ok);
            n_checks++; if (!ok || req_bnk !== 4'b0001 || req_addr !== 2'(k)) begin n_fail++; $display("FAIL sat_pos_k%0d: got ok=%b bnk=%b addr=%0d expected 1/0001/%0d", k, ok, req_bnk, req_addr, k); end
            serve();
        end
        n_checks++; if (sweep_done !== 1'b1) begin n_fail++; $display("FAIL sat_sweep_done: got %b expected 1", sweep_done); end
        n_checks++; if (sweep_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_sweep_count: got %h expected FFFF", sweep_count); end
    endtask

    initial begin
        rst_a          = 1'b1;
        scrub_enable   = 1'b0;
        scrub_interval = '0;
        scrub_bnk_mask = '0;
        req_ack        = 1'b0;
        scrub_proc     = 1'b0;
        test_reset();
        test_pacing();
        test_sweep_wrap();
        test_hold_ack();
        test_disable_wait();
        test_mask_change();
        test_stray();
        test_reset_cmpl();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
